// File: rtl/pipelined_adder_pkg.sv
// Shared constants and the stage-count helper for pipelined_adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Guard against a zero chunk so elaboration reaches the parameter check.
  function automatic int stage_count(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit ripple-carry adder used by each pipeline stage; also exports
// the carry into its MSB so the top stage can derive signed overflow.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cm
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[W];
  assign cm = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: stage k adds chunk k using the carry registered by
// stage k-1. Optional signed-overflow output under PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cIn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  // Handshake: a transfer happens on in_valid & in_ready, a result is
  // consumed on out_valid & out_ready. The whole pipe moves as one unit
  // (advance) whenever the output register is empty or being drained, so
  // a stalled output freezes every stage and in_ready drops with it.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands still to be added ride LSB-aligned; finished sum chunks
    // accumulate below the current chunk so they leave de-skewed.
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]    xi;
    logic [IW-1:0]    yi;
    logic             vi;
    logic             ci;
    logic [SW-1:0]    sn;
    logic [CHUNK-1:0] s_ch;
    logic             co;
    logic             cm;
    logic             vr;
    logic             cr;
    logic [SW-1:0]    sr;

    adder_slice #(.W(CHUNK)) u_slice (
      .a  (xi[CHUNK-1:0]),
      .b  (yi[CHUNK-1:0]),
      .ci (ci),
      .s  (s_ch),
      .co (co),
      .cm (cm)
    );

    if (k == 0) begin : g_in
      assign xi = x;
      assign yi = y;
      assign vi = in_valid;
      assign ci = cIn;
      assign sn = s_ch;
    end else begin : g_in
      assign xi = g_stage[k-1].g_ops.xr;
      assign yi = g_stage[k-1].g_ops.yr;
      assign vi = g_stage[k-1].vr;
      assign ci = g_stage[k-1].cr;
      assign sn = {s_ch, g_stage[k-1].sr};
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IW-CHUNK-1:0] xr;
      logic [IW-CHUNK-1:0] yr;

      always_ff @(posedge clk) begin
        if (rst) begin
          xr <= '0;
          yr <= '0;
        end else if (advance) begin
          xr <= xi[IW-1:CHUNK];
          yr <= yi[IW-1:CHUNK];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vr <= 1'b0;
        cr <= 1'b0;
        sr <= '0;
      end else if (advance) begin
        vr <= vi;
        cr <= co;
        sr <= sn;
      end
    end
  end

  assign sum       = g_stage[STAGES-1].sr;
  assign cOut      = g_stage[STAGES-1].cr;
  assign out_valid = g_stage[STAGES-1].vr;

`ifdef PIPELINED_ADDER_OVF_EN
  // Registered beside the last chunk so it lines up with sum/cOut.
  logic ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (advance) begin
      ovf_r <= g_stage[STAGES-1].cm ^ g_stage[STAGES-1].co;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule
